op_sequencer: RTL and testbench
===============================

# op_sequencer

Command-queue sequencer for the 8-bit bit-serial logic processor. It accepts a stream of {function, routing} commands from a host and runs each one as a full serial pass of the register unit. For each pass it drives the shift enable and holds F/R stable for exactly WIDTH cycles. It also arbitrates operand loads against running operations, so a load never lands in the middle of a pass. It sits between the synchronized switch/button inputs and the register_unit/compute/router datapath, and replaces direct button-driven execution.

## Interface
Parameters:
- WIDTH, 8, shift cycles per operation (register width)
- DEPTH, 4, command queue entries (power of 2, ≥2)

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- Cmd_Valid  in  1  host offers a command
- Cmd_Ready  out  1  queue can accept; push occurs when Cmd_Valid && Cmd_Ready
- Cmd_F  in  3  function select of offered command
- Cmd_R  in  2  routing select of offered command
- LoadA_Req  in  1  level request to load register A (synchronized)
- LoadB_Req  in  1  level request to load register B (synchronized)
- Ld_A  out  1  load strobe to register unit A
- Ld_B  out  1  load strobe to register unit B
- Shift_En  out  1  shift enable to register unit
- F  out  3  function select to compute unit
- R  out  2  routing select to router
- Busy  out  1  high whenever state ≠ IDLE
- Op_Done  out  1  one-cycle pulse at end of each operation
- Level  out  $clog2(DEPTH+1)  queued command count
- Ops_Count  out  8  completed operations, wraps 255→0

## Operation
- Queue: a FIFO of DEPTH {F,R} entries, with circular read and write pointers that wrap at DEPTH.
  - Cmd_Ready = (Level < DEPTH), combinational from Level only.
  - A push and a pop in the same cycle leave Level unchanged.
  - A push offered while full is ignored and the command is lost; the host must hold it.
- FSM states: IDLE, SHIFT, DONE, LOAD, HOLD.
- IDLE:
  - If Level ≠ 0: pop the head into the F/R registers, clear the shift counter, go to SHIFT.
  - Else if LoadA_Req || LoadB_Req: latch both request bits, go to LOAD.
  - Queued commands take priority over loads; a load is serviced only once the queue is empty.
- SHIFT:
  - Shift_En = 1; the counter increments each cycle.
  - On the WIDTH-th cycle (counter = WIDTH−1), go to DONE.
  - F/R stay constant for the whole pass.
- DONE: Op_Done = 1 for one cycle; Ops_Count += 1; go to IDLE.
- LOAD: Ld_A/Ld_B = the latched request bits for exactly one cycle; go to HOLD.
- HOLD: stay until LoadA_Req and LoadB_Req are both low, then go to IDLE. This gives one load per button press.
- Control outputs (Shift_En, Ld_A, Ld_B, Op_Done, Busy) decode from the state register only, with no input-to-output combinational path.
- F/R keep the last popped value outside SHIFT.
- Reset, from any state including mid-SHIFT:
  - Queue is flushed and Level = 0.
  - State returns to IDLE and Ops_Count = 0.
  - The partial pass is abandoned; register contents are not restored.

## Timing
- Reset values: Cmd_Ready = 1, all other outputs 0 (F = 0, R = 0, Level = 0).
- Push at edge t:
  - Level = 1 after t.
  - Pop at edge t+1.
  - Shift_En high from t+1 through t+1+WIDTH (WIDTH cycles).
  - Op_Done high for the cycle after edge t+1+WIDTH.
  - Back in IDLE after t+2+WIDTH.
- Back-to-back operations: WIDTH+2 cycles from one pop to the next.
- Load: Ld_x asserts the cycle after IDLE samples a request. Minimum request-to-strobe latency is 1 cycle.
- A load request held during an operation is strobed 1 cycle after the last queued op's DONE→IDLE transition.
- LoadA_Req and LoadB_Req sampled high together produce simultaneous Ld_A and Ld_B pulses in the same cycle.

## Test plan
- Reset: assert Reset for 2 cycles with Cmd_Valid high → Cmd_Ready = 1, Level = 0, all other outputs 0, no push accepted.
- Single op (WIDTH = 8): push F = 3'b010, R = 2'b01 at edge 0 → F/R = 010/01 with Shift_En high for exactly 8 cycles (edges 1–9); Op_Done pulses once; Ops_Count = 1; Busy low after edge 10.
- Overflow: push 6 commands on consecutive cycles, with F = 0..5 → first 5 accepted; Cmd_Ready low after the 5th; 6th dropped; ops execute in order F = 0..4; Ops_Count = 5 after 5×10 cycles.
- Deferred load: raise LoadA_Req during the 3rd shift cycle and hold for 20 cycles → no Ld_A during SHIFT; single Ld_A pulse 1 cycle after return to IDLE; no second pulse until release.
- Simultaneous load, then reset mid-op: LoadA_Req = LoadB_Req = 1 while idle → Ld_A and Ld_B pulse in the same cycle. Then queue 2 ops and assert Reset at the 4th shift cycle → next cycle Shift_En = 0, Level = 0, Ops_Count = 0, no Op_Done.
- Count wrap: complete 256 ops → Ops_Count returns to 0; Op_Done pulse count = 256.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: command-queue sequencer for the 8-bit bit-serial logic processor.
// Queues {F,R} commands and runs each as one WIDTH-cycle serial pass. Operand
// loads are deferred until the queue is empty and no pass is in progress.
module op_sequencer #(
  parameter int WIDTH = 8,  // shift cycles per operation
  parameter int DEPTH = 4   // command queue entries (power of 2, >= 2)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Cmd_Valid,
  output logic                         Cmd_Ready,
  input  logic [2:0]                   Cmd_F,
  input  logic [1:0]                   Cmd_R,
  input  logic                         LoadA_Req,
  input  logic                         LoadB_Req,
  output logic                         Ld_A,
  output logic                         Ld_B,
  output logic                         Shift_En,
  output logic [2:0]                   F,
  output logic [1:0]                   R,
  output logic                         Busy,
  output logic                         Op_Done,
  output logic [$clog2(DEPTH+1)-1:0]   Level,
  output logic [7:0]                   Ops_Count
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [4:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_f;
  logic [1:0]    r_r;
  logic          r_ld_a;
  logic          r_ld_b;
  logic [7:0]    r_ops;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_any_req;
  logic          w_take_load;

  assign w_ready     = (r_level < LW'(DEPTH));
  assign w_push      = Cmd_Valid && w_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
  assign w_any_req   = LoadA_Req || LoadB_Req;
  // Loads are only taken from IDLE with an empty queue, so queued work wins.
  assign w_take_load = (r_state == S_IDLE) && (r_level == '0) && w_any_req;

  // Next-state decode for the pass/load controller.
  always_comb begin
    // NOTE: default assignment first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0)  w_state_nxt = S_SHIFT;
        else if (w_any_req) w_state_nxt = S_LOAD;
      end
      S_SHIFT: if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_LOAD:  w_state_nxt = S_HOLD;
      S_HOLD:  if (!w_any_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any pass in progress.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Queue storage, written on every accepted push.
  always_ff @(posedge Clk) begin
    // NOTE: storage is not reset; entries are only read after the pointers/level mark them valid.
    if (w_push) r_mem[r_wr_ptr] <= {Cmd_F, Cmd_R};
  end

  // Queue pointers and occupancy; simultaneous push and pop leave Level unchanged.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // F/R capture on pop (held until the next pop) and the per-pass shift counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_f   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else if (w_pop) begin
      {r_f, r_r} <= r_mem[r_rd_ptr];
      r_cnt      <= '0;
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Latch which registers asked to load at the moment the load is accepted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ld_a <= 1'b0;
      r_ld_b <= 1'b0;
    end else if (w_take_load) begin
      r_ld_a <= LoadA_Req;
      r_ld_b <= LoadB_Req;
    end
  end

  // Completed-operation counter, bumped once per DONE cycle, wraps naturally.
  always_ff @(posedge Clk) begin
    if (Reset)                  r_ops <= '0;
    else if (r_state == S_DONE) r_ops <= r_ops + 1'b1;
  end

  // Control outputs decode from registered state only.
  assign Shift_En  = (r_state == S_SHIFT);
  assign Op_Done   = (r_state == S_DONE);
  assign Busy      = (r_state != S_IDLE);
  assign Ld_A      = (r_state == S_LOAD) && r_ld_a;
  assign Ld_B      = (r_state == S_LOAD) && r_ld_b;
  assign F         = r_f;
  assign R         = r_r;
  assign Cmd_Ready = w_ready;
  assign Level     = r_level;
  assign Ops_Count = r_ops;

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed and randomized checks of op_sequencer against a
// transaction-level model (command queue + countdown timer for each pass).
module tb_op_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Cmd_Valid = 1'b0;
  logic       Cmd_Ready;
  logic [2:0] Cmd_F = '0;
  logic [1:0] Cmd_R = '0;
  logic       LoadA_Req = 1'b0;
  logic       LoadB_Req = 1'b0;
  logic       Ld_A, Ld_B, Shift_En, Busy, Op_Done;
  logic [2:0] F;
  logic [1:0] R;
  logic [2:0] Level;
  logic [7:0] Ops_Count;

  always #5 Clk = ~Clk;

  op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_F(Cmd_F), .Cmd_R(Cmd_R),
    .LoadA_Req(LoadA_Req), .LoadB_Req(LoadB_Req),
    .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .F(F), .R(R),
    .Busy(Busy), .Op_Done(Op_Done), .Level(Level), .Ops_Count(Ops_Count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of pending commands, a countdown of cycles left in
  // the current pass (WIDTH shift cycles then one done cycle), and load flags.
  logic [4:0] mq[$];
  int         m_left;
  bit         m_ld_now, m_hold, m_lda, m_ldb, m_pushed;
  logic [2:0] m_f;
  logic [1:0] m_r;
  logic [7:0] m_ops;

  // Directed-step bookkeeping.
  int         n_sh, n_done, n_ld, n_ldb, ld_at, cyc, n_push;
  bit         prev_sh;
  logic [2:0] fq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [4:0] c;
    m_pushed = 1'b0;
    if (Reset) begin
      mq.delete();
      m_left = 0; m_ld_now = 0; m_hold = 0; m_lda = 0; m_ldb = 0;
      m_f = '0; m_r = '0; m_ops = '0;
      return;
    end
    m_pushed = Cmd_Valid && (mq.size() < DEPTH);
    if (m_ld_now) begin
      m_ld_now = 0;
      m_hold   = 1;
    end else if (m_hold) begin
      if (!LoadA_Req && !LoadB_Req) m_hold = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_ops = m_ops + 8'd1;
    end else if (mq.size() > 0) begin
      c = mq.pop_front();
      {m_f, m_r} = c;
      m_left = WIDTH + 1;
    end else if (LoadA_Req || LoadB_Req) begin
      m_ld_now = 1;
      m_lda    = LoadA_Req;
      m_ldb    = LoadB_Req;
    end
    if (m_pushed) mq.push_back({Cmd_F, Cmd_R});
  endtask

  task automatic check_outputs();
    logic [31:0] obs, exp;
    obs = {10'd0, Cmd_Ready, Ld_A, Ld_B, Shift_En, Busy, Op_Done, F, R, Level, Ops_Count};
    exp = {10'd0, (mq.size() < DEPTH), (m_ld_now && m_lda), (m_ld_now && m_ldb),
           (m_left > 1), (m_left > 0 || m_ld_now || m_hold), (m_left == 1),
           m_f, m_r, 3'(mq.size()), m_ops};
    check("outs{rdy,lda,ldb,sh,busy,done,F,R,lvl,ops}", obs, exp);
  endtask

  // One clock: update the model with the inputs the DUT sampled, then compare.
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    Cmd_Valid = 0; LoadA_Req = 0; LoadB_Req = 0;
    Reset = 1;
    step();
    Reset = 0;
  endtask

  initial begin
    // Reset for two cycles with a command offered: nothing may be accepted.
    Cmd_Valid = 1; Cmd_F = 3'b111; Cmd_R = 2'b11;
    step();
    step();
    check("rst_ready", Cmd_Ready, 1);
    check("rst_level", Level, 0);
    check("rst_busy", Busy, 0);
    check("rst_fr", {F, R}, 0);
    check("rst_ops", Ops_Count, 0);
    Reset = 0; Cmd_Valid = 0;
    step();
    check("rst_nopush_level", Level, 0);

    // Single op: push at edge 0, eight shift cycles, one done pulse.
    Cmd_Valid = 1; Cmd_F = 3'b010; Cmd_R = 2'b01;
    step();
    Cmd_Valid = 0;
    check("single_level", Level, 1);
    n_sh = 0; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Shift_En) begin
        n_sh++;
        check("single_fr", {F, R}, 5'b010_01);
      end
      if (Op_Done) n_done++;
      if (i == 0) check("single_shift_start", Shift_En, 1);
      if (i == 9) check("single_busy_after_edge10", Busy, 0);
    end
    check("single_shift_cycles", n_sh, 8);
    check("single_done_pulses", n_done, 1);
    check("single_ops", Ops_Count, 1);

    // Overflow: six back-to-back pushes, F = 0..5; the sixth is dropped.
    do_reset();
    prev_sh = 0;
    fq.delete();
    for (int i = 0; i < 6; i++) begin
      Cmd_Valid = 1; Cmd_F = 3'(i); Cmd_R = 2'($urandom);
      step();
      if (Shift_En && !prev_sh) fq.push_back(F);
      prev_sh = Shift_En;
      if (i == 4) check("ovf_ready_low", Cmd_Ready, 0);
    end
    Cmd_Valid = 0;
    check("ovf_level", Level, 4);
    for (int i = 0; i < 55; i++) begin
      step();
      if (Shift_En && !prev_sh) fq.push_back(F);
      prev_sh = Shift_En;
    end
    check("ovf_num_ops", fq.size(), 5);
    for (int k = 0; k < fq.size(); k++) check("ovf_order", fq[k], k);
    check("ovf_ops", Ops_Count, 5);

    // Deferred load: request raised mid-pass and held for 20 cycles.
    do_reset();
    Cmd_Valid = 1; Cmd_F = 3'($urandom); Cmd_R = 2'($urandom);
    step();
    Cmd_Valid = 0;
    step(); step(); step();
    LoadA_Req = 1;
    n_ld = 0; n_ldb = 0; ld_at = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (Ld_A) begin
        n_ld++;
        if (ld_at < 0) ld_at = i;
      end
      if (Ld_B) n_ldb++;
    end
    check("defer_lda_pulses", n_ld, 1);
    check("defer_lda_cycle", ld_at, 7);
    check("defer_ldb_pulses", n_ldb, 0);
    check("defer_hold_busy", Busy, 1);
    LoadA_Req = 0;
    step(); step();
    check("defer_release_idle", Busy, 0);

    // Simultaneous load, then reset in the middle of a pass.
    do_reset();
    LoadA_Req = 1; LoadB_Req = 1;
    step();
    check("sim_lda", Ld_A, 1);
    check("sim_ldb", Ld_B, 1);
    LoadA_Req = 0; LoadB_Req = 0;
    step(); step();
    check("sim_idle", Busy, 0);
    Cmd_Valid = 1; Cmd_F = 3'($urandom); Cmd_R = 2'($urandom);
    step();
    Cmd_F = 3'($urandom); Cmd_R = 2'($urandom);
    step();
    Cmd_Valid = 0;
    step(); step(); step();
    check("midrst_level_before", Level, 1);
    Reset = 1;
    step();
    check("midrst_shift", Shift_En, 0);
    check("midrst_level", Level, 0);
    check("midrst_ops", Ops_Count, 0);
    check("midrst_done", Op_Done, 0);
    Reset = 0;
    step();
    check("midrst_idle", Busy, 0);

    // Randomized traffic with occasional load requests and resets.
    for (int i = 0; i < 2000; i++) begin
      Cmd_Valid = ($urandom_range(0, 3) != 0);
      Cmd_F = 3'($urandom);
      Cmd_R = 2'($urandom);
      if ($urandom_range(0, 15) == 0) LoadA_Req = ~LoadA_Req;
      if ($urandom_range(0, 15) == 0) LoadB_Req = ~LoadB_Req;
      Reset = ($urandom_range(0, 199) == 0);
      step();
    end
    Reset = 0; LoadA_Req = 0; LoadB_Req = 0; Cmd_Valid = 0;

    // Count wrap: 256 completed operations bring Ops_Count back to 0.
    do_reset();
    n_push = 0; n_done = 0; cyc = 0;
    while (cyc < 4000) begin
      Cmd_Valid = (n_push < 256);
      Cmd_F = 3'($urandom);
      Cmd_R = 2'($urandom);
      step();
      cyc++;
      if (m_pushed) n_push++;
      if (Op_Done) n_done++;
      if (n_push == 256 && Level == 0 && !Busy) break;
    end
    check("wrap_within_budget", (cyc < 4000), 1);
    check("wrap_done_pulses", n_done, 256);
    check("wrap_ops", Ops_Count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
